// File: rtl/store_buffer.sv
// Store buffer: turns byte/half/word stores into lane-aligned data plus byte masks and drains them into four byte banks.
// Optional STORE_COALESCE_EN merges a store into the newest entry when both address the same word.
`ifndef BYTE
`define BYTE 2'b00
`endif
`ifndef HALF
`define HALF 2'b01
`endif
`ifndef WORD
`define WORD 2'b10
`endif

module store_buffer #(
  parameter int DEPTH       = 4,
  parameter int INDEX_WIDTH = 17
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   store_valid,
  output logic                   store_ready,
  input  logic [31:0]            store_address,
  input  logic [31:0]            store_data,
  input  logic [1:0]             store_size,
  input  logic                   mem_grant,
  output logic [3:0]             bank_write,
  output logic [INDEX_WIDTH-1:0] bank_index,
  output logic [31:0]            bank_data,
  output logic                   empty,
  output logic                   full,
  output logic                   store_misaligned
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INDEX_WIDTH-1:0] r_idxMem  [DEPTH];
  logic [3:0]             r_maskMem [DEPTH];
  logic [31:0]            r_dataMem [DEPTH];

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             r_misaligned;

  logic [1:0]             w_offset;
  logic [3:0]             w_mask;
  logic [31:0]            w_data;
  logic                   w_misaligned;
  logic [INDEX_WIDTH-1:0] w_index;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_merge;
  logic                   w_push;

  assign w_offset = store_address[1:0];
  assign w_index  = store_address[INDEX_WIDTH+1:2];

  generate
    if (INDEX_WIDTH < 30) begin : gUnusedAddr
      logic w_unusedAddr;
      assign w_unusedAddr = ^store_address[31:INDEX_WIDTH+2];
    end
  endgenerate

  // Lane formation; a misaligned request keeps a zero mask and is dropped.
  always_comb begin
    w_mask       = 4'b0000;
    w_data       = 32'h0;
    w_misaligned = 1'b0;
    case (store_size)
      `BYTE: begin
        w_mask = 4'b0001 << w_offset;
        w_data = {24'h0, store_data[7:0]} << {w_offset, 3'b000};
      end
      `HALF: begin
        if (w_offset[0]) begin
          w_misaligned = 1'b1;
        end else if (w_offset[1]) begin
          w_mask = 4'b1100;
          w_data = {store_data[15:0], 16'h0};
        end else begin
          w_mask = 4'b0011;
          w_data = {16'h0, store_data[15:0]};
        end
      end
      default: begin
        if (w_offset != 2'b00) begin
          w_misaligned = 1'b1;
        end else begin
          w_mask = 4'b1111;
          w_data = store_data;
        end
      end
    endcase
  end

  assign full        = (r_count == (PTR_W+1)'(DEPTH));
  assign empty       = (r_count == '0);
  assign store_ready = !full;
  assign w_accept    = store_valid && !full;
  assign w_pop       = !empty && mem_grant;

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0] w_tailPtr;
  assign w_tailPtr = r_wrPtr - 1'b1;
  // The tail is also the head when only one entry exists; never merge into an entry leaving this cycle.
  assign w_merge = w_accept && !w_misaligned && !empty &&
                   (r_idxMem[w_tailPtr] == w_index) &&
                   !(w_pop && (r_count == (PTR_W+1)'(1)));
`else
  assign w_merge = 1'b0;
`endif

  assign w_push = w_accept && !w_misaligned && !w_merge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_accept && w_misaligned;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_idxMem[r_wrPtr]  <= w_index;
      r_maskMem[r_wrPtr] <= w_mask;
      r_dataMem[r_wrPtr] <= w_data;
    end
`ifdef STORE_COALESCE_EN
    else if (w_merge) begin
      r_maskMem[w_tailPtr] <= r_maskMem[w_tailPtr] | w_mask;
      for (int k = 0; k < 4; k++) begin
        if (w_mask[k]) r_dataMem[w_tailPtr][8*k +: 8] <= w_data[8*k +: 8];
      end
    end
`endif
  end

  assign bank_write       = w_pop ? r_maskMem[r_rdPtr] : 4'b0000;
  assign bank_index       = r_idxMem[r_rdPtr];
  assign bank_data        = r_dataMem[r_rdPtr];
  assign store_misaligned = r_misaligned;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain timing, lane placement, full/wrap, misalignment, async reset and coalescing.
`ifndef BYTE
`define BYTE 2'b00
`endif
`ifndef HALF
`define HALF 2'b01
`endif
`ifndef WORD
`define WORD 2'b10
`endif

module tb_store_buffer;

  logic        clock;
  logic        reset;
  logic        store_valid;
  logic        store_ready;
  logic [31:0] store_address;
  logic [31:0] store_data;
  logic [1:0]  store_size;
  logic        mem_grant;
  logic [3:0]  bank_write;
  logic [16:0] bank_index;
  logic [31:0] bank_data;
  logic        empty;
  logic        full;
  logic        store_misaligned;

  int compared;
  int mismatched;

  store_buffer #(.DEPTH(4), .INDEX_WIDTH(17)) dut (
    .clock            (clock),
    .reset            (reset),
    .store_valid      (store_valid),
    .store_ready      (store_ready),
    .store_address    (store_address),
    .store_data       (store_data),
    .store_size       (store_size),
    .mem_grant        (mem_grant),
    .bank_write       (bank_write),
    .bank_index       (bank_index),
    .bank_data        (bank_data),
    .empty            (empty),
    .full             (full),
    .store_misaligned (store_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input logic grant);
    store_valid   = valid;
    store_address = addr;
    store_data    = data;
    store_size    = size;
    mem_grant     = grant;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input logic grant);
    applyStimulus(1'b0, 32'h0, 32'h0, `WORD, grant);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    idle(1'b0);
    step();
    step();
    reset = 1'b0;
    #1;

    checkOutput("reset_empty", {31'h0, empty}, 32'h1);
    checkOutput("reset_full", {31'h0, full}, 32'h0);
    checkOutput("reset_ready", {31'h0, store_ready}, 32'h1);
    checkOutput("reset_misaligned", {31'h0, store_misaligned}, 32'h0);
    checkOutput("reset_bank_write", {28'h0, bank_write}, 32'h0);

    // Word store with grant held: written the cycle after acceptance.
    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF, `WORD, 1'b1);
    checkOutput("word_no_same_cycle_write", {28'h0, bank_write}, 32'h0);
    step();
    idle(1'b1);
    checkOutput("word_bank_write", {28'h0, bank_write}, 32'hF);
    checkOutput("word_bank_index", {15'h0, bank_index}, 32'h10);
    checkOutput("word_bank_data", bank_data, 32'hDEADBEEF);
    step();
    checkOutput("word_empty_after", {31'h0, empty}, 32'h1);
    checkOutput("word_no_write_after", {28'h0, bank_write}, 32'h0);

    // Byte and half into upper lanes, queued while the port is busy.
    applyStimulus(1'b1, 32'h103, 32'h000000AB, `BYTE, 1'b0);
    step();
    applyStimulus(1'b1, 32'h106, 32'h00001234, `HALF, 1'b0);
    step();
    idle(1'b0);
    checkOutput("two_not_empty", {31'h0, empty}, 32'h0);
    checkOutput("two_not_full", {31'h0, full}, 32'h0);
    checkOutput("two_no_grant_write", {28'h0, bank_write}, 32'h0);
    idle(1'b1);
    checkOutput("byte_mask", {28'h0, bank_write}, 32'h8);
    checkOutput("byte_lane3", {24'h0, bank_data[31:24]}, 32'hAB);
    checkOutput("byte_index", {15'h0, bank_index}, 32'h40);
    step();
    checkOutput("half_mask", {28'h0, bank_write}, 32'hC);
    checkOutput("half_lanes23", {16'h0, bank_data[31:16]}, 32'h1234);
    checkOutput("half_index", {15'h0, bank_index}, 32'h41);
    step();
    checkOutput("two_drained_empty", {31'h0, empty}, 32'h1);

    // Fill to DEPTH, hold a fifth request pending, then free one slot.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 32'h1000 + 32'(i), `WORD, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'h10, 32'h5555, `WORD, 1'b0);
    checkOutput("fill_full", {31'h0, full}, 32'h1);
    checkOutput("fill_not_ready", {31'h0, store_ready}, 32'h0);
    step();
    checkOutput("fifth_held_full", {31'h0, full}, 32'h1);
    applyStimulus(1'b1, 32'h10, 32'h5555, `WORD, 1'b1);
    checkOutput("full_pop_data", bank_data, 32'h1000);
    checkOutput("full_pop_not_ready", {31'h0, store_ready}, 32'h0);
    step();
    applyStimulus(1'b1, 32'h10, 32'h5555, `WORD, 1'b0);
    checkOutput("after_pop_ready", {31'h0, store_ready}, 32'h1);
    step();
    idle(1'b0);
    checkOutput("fifth_accepted_full", {31'h0, full}, 32'h1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_order_data_%0d", i), bank_data, (i < 3) ? 32'h1001 + 32'(i) : 32'h5555);
      checkOutput($sformatf("wrap_order_index_%0d", i), {15'h0, bank_index}, 32'(i + 1) & 32'h7);
      checkOutput($sformatf("wrap_order_mask_%0d", i), {28'h0, bank_write}, 32'hF);
      step();
    end
    checkOutput("wrap_empty", {31'h0, empty}, 32'h1);

    // Misaligned half and word: one pulse each, nothing queued.
    applyStimulus(1'b1, 32'h101, 32'h0000BEEF, `HALF, 1'b1);
    step();
    idle(1'b1);
    checkOutput("mis_half_pulse", {31'h0, store_misaligned}, 32'h1);
    checkOutput("mis_half_empty", {31'h0, empty}, 32'h1);
    checkOutput("mis_half_no_write", {28'h0, bank_write}, 32'h0);
    step();
    checkOutput("mis_half_pulse_end", {31'h0, store_misaligned}, 32'h0);
    applyStimulus(1'b1, 32'h102, 32'hCAFEF00D, `WORD, 1'b1);
    step();
    idle(1'b1);
    checkOutput("mis_word_pulse", {31'h0, store_misaligned}, 32'h1);
    checkOutput("mis_word_empty", {31'h0, empty}, 32'h1);
    checkOutput("mis_word_no_write", {28'h0, bank_write}, 32'h0);
    step();
    checkOutput("mis_word_pulse_end", {31'h0, store_misaligned}, 32'h0);

    // Asynchronous reset in the middle of a granted drain.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), `WORD, 1'b0);
      step();
    end
    idle(1'b1);
    checkOutput("pre_reset_write", {28'h0, bank_write}, 32'hF);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_write", {28'h0, bank_write}, 32'h0);
    checkOutput("async_reset_empty", {31'h0, empty}, 32'h1);
    step();
    reset = 1'b0;
    #1;
    checkOutput("post_reset_write", {28'h0, bank_write}, 32'h0);
    step();
    checkOutput("post_reset_write_2", {28'h0, bank_write}, 32'h0);
    checkOutput("post_reset_ready", {31'h0, store_ready}, 32'h1);

    // Two bytes to the same word; merged into one entry only with coalescing.
    applyStimulus(1'b1, 32'h200, 32'h11, `BYTE, 1'b0);
    step();
    applyStimulus(1'b1, 32'h201, 32'h22, `BYTE, 1'b0);
    step();
    idle(1'b1);
    begin
      logic [31:0] expMask1;
      logic [31:0] expLow;
      logic [31:0] expEmpty2;
      logic [31:0] expMask2;
`ifdef STORE_COALESCE_EN
      expMask1  = 32'h3;
      expLow    = 32'h2211;
      expEmpty2 = 32'h1;
      expMask2  = 32'h0;
`else
      expMask1  = 32'h1;
      expLow    = 32'h11;
      expEmpty2 = 32'h0;
      expMask2  = 32'h2;
`endif
      checkOutput("coal_first_mask", {28'h0, bank_write}, expMask1);
      checkOutput("coal_first_low", {16'h0, bank_data[15:0]} & {16'h0, expMask1[1] ? 16'hFFFF : 16'h00FF}, expLow);
      checkOutput("coal_index", {15'h0, bank_index}, 32'h80);
      step();
      checkOutput("coal_second_empty", {31'h0, empty}, expEmpty2);
      checkOutput("coal_second_mask", {28'h0, bank_write}, expMask2);
      step();
      checkOutput("coal_final_empty", {31'h0, empty}, 32'h1);
    end

    idle(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
